// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port memory controller between the CPU, the PPU
// and a periodic refresh scheduler. One access is in flight at a time; each
// access runs IDLE -> CMD -> WAIT_HI -> WAIT_LO -> DONE against mem_busy.
module mem_arbiter #(
  parameter int REFRESH_INTERVAL = 400,
  parameter int REFRESH_URGENT   = 4,
  parameter int CPU_MAX_SKIP     = 2,
  parameter int BUSY_TIMEOUT     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [21:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        ppu_req,
  input  logic [21:0] ppu_addr,
  output logic [7:0]  ppu_dout,
  output logic        ppu_ack,
  output logic        mem_read_a,
  output logic        mem_read_b,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout_a,
  input  logic [7:0]  mem_dout_b,
  input  logic        mem_busy,
  output logic [2:0]  refresh_owed,
  output logic        fail
);

  localparam int RC_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int TMO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int SKIP_W = $clog2(CPU_MAX_SKIP + 1);

  localparam logic [RC_W-1:0]   RC_LAST     = RC_W'(REFRESH_INTERVAL - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(BUSY_TIMEOUT - 1);
  localparam logic [SKIP_W-1:0] SKIP_MAX    = SKIP_W'(CPU_MAX_SKIP);
  localparam logic [2:0]        OWED_URGENT = 3'(REFRESH_URGENT);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT_HI, S_WAIT_LO, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_PPU, OWN_REF} own_t;

  state_t            state, state_nx;
  own_t              owner, grant_own;
  logic              grant;
  logic              is_write;
  logic              tmo_hit;
  logic              tick;
  logic              ref_grant;
  logic [RC_W-1:0]   ref_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [SKIP_W-1:0] cpu_skip;

  // Saturating increment of the CPU skip count.
  function automatic logic [SKIP_W-1:0] skip_sat_inc(input logic [SKIP_W-1:0] v);
    return (v == SKIP_MAX) ? v : v + 1'b1;
  endfunction

  // Pending-refresh count update; a tick and a grant together cancel out.
  function automatic logic [2:0] owed_update(input logic [2:0] v, input logic inc,
                                             input logic dec);
    if (inc && !dec) return (v == 3'd7) ? v : v + 3'd1;
    if (dec && !inc) return v - 3'd1;
    return v;
  endfunction

  assign tick      = (ref_cnt == RC_LAST);
  assign ref_grant = grant && (grant_own == OWN_REF);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state, including the IDLE arbitration (only while the controller is idle).
  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    grant_own = OWN_CPU;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!mem_busy) begin
          if (refresh_owed >= OWED_URGENT) begin
            grant = 1'b1; grant_own = OWN_REF;
          end else if (cpu_req && (cpu_skip == SKIP_MAX)) begin
            grant = 1'b1; grant_own = OWN_CPU;
          end else if (ppu_req) begin
            grant = 1'b1; grant_own = OWN_PPU;
          end else if (cpu_req) begin
            grant = 1'b1; grant_own = OWN_CPU;
          end else if (refresh_owed != 3'd0) begin
            grant = 1'b1; grant_own = OWN_REF;
          end
        end
        if (grant) state_nx = S_CMD;
      end
      S_CMD:     state_nx = S_WAIT_HI;
      S_WAIT_HI: begin
        if (mem_busy) begin
          state_nx = S_WAIT_LO;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_WAIT_LO: if (!mem_busy) state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Command pulses live only in CMD; acks only in DONE, and never for refresh.
  always_comb begin
    mem_read_a  = (state == S_CMD) && (owner == OWN_CPU) && !is_write;
    mem_write   = (state == S_CMD) && (owner == OWN_CPU) && is_write;
    mem_read_b  = (state == S_CMD) && (owner == OWN_PPU);
    mem_refresh = (state == S_CMD) && (owner == OWN_REF);
    cpu_ack     = (state == S_DONE) && (owner == OWN_CPU);
    ppu_ack     = (state == S_DONE) && (owner == OWN_PPU);
  end

  // Refresh timer, pending-refresh count and sticky failure flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt      <= '0;
      refresh_owed <= 3'd0;
      fail         <= 1'b0;
    end else begin
      ref_cnt      <= tick ? '0 : ref_cnt + 1'b1;
      refresh_owed <= owed_update(refresh_owed, tick, ref_grant);
      if ((tick && !ref_grant && (refresh_owed == 3'd7)) || tmo_hit) fail <= 1'b1;
    end
  end

  // Latch the granted request and keep the CPU from starving behind the PPU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= OWN_CPU;
      is_write <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      cpu_skip <= '0;
    end else if (grant) begin
      owner    <= grant_own;
      is_write <= (grant_own == OWN_CPU) && cpu_we;
      mem_din  <= cpu_din;
      if (grant_own == OWN_CPU) mem_addr <= cpu_addr;
      else if (grant_own == OWN_PPU) mem_addr <= ppu_addr;
      if (grant_own == OWN_CPU) cpu_skip <= '0;
      else if ((grant_own == OWN_PPU) && cpu_req) cpu_skip <= skip_sat_inc(cpu_skip);
    end
  end

  // Count WAIT_HI cycles spent without the controller raising busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   tmo_cnt <= '0;
    else if (state == S_WAIT_HI) tmo_cnt <= tmo_cnt + 1'b1;
    else                         tmo_cnt <= '0;
  end

  // Capture read data when busy falls; a timed-out read returns 0x00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_dout <= '0;
      ppu_dout <= '0;
    end else if ((state == S_WAIT_LO) && !mem_busy) begin
      if ((owner == OWN_CPU) && !is_write) cpu_dout <= mem_dout_a;
      if (owner == OWN_PPU)                ppu_dout <= mem_dout_b;
    end else if (tmo_hit) begin
      if ((owner == OWN_CPU) && !is_write) cpu_dout <= 8'h00;
      if (owner == OWN_PPU)                ppu_dout <= 8'h00;
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port NES memory controller among three clients: CPU (read/write), PPU (read-only) and a refresh scheduler.
- Sits between the NES core and the memory controller.
- Sequences each access against the controller's busy handshake and returns read data with a one-cycle ack.
- Generates periodic refresh requests and escalates them when too many are pending.

Parameters:
- REFRESH_INTERVAL, 400, cycles between refresh ticks.
- REFRESH_URGENT, 4, refresh_owed level at which refresh pre-empts all clients.
- CPU_MAX_SKIP, 2, consecutive PPU wins over a waiting CPU before the CPU is forced ahead.
- BUSY_TIMEOUT, 8, cycles to wait in WAIT_HI for mem_busy to rise before declaring failure.

Ports:
- clk  in  1  main logic clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  level request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  22  CPU byte address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data; valid while cpu_ack is high.
- cpu_ack  out  1  one-cycle completion pulse.
- ppu_req  in  1  level read request; held until ppu_ack.
- ppu_addr  in  22  PPU byte address.
- ppu_dout  out  8  PPU read data; valid while ppu_ack is high.
- ppu_ack  out  1  one-cycle completion pulse.
- mem_read_a  out  1  controller read (CPU port), one-cycle pulse.
- mem_read_b  out  1  controller read (PPU port), one-cycle pulse.
- mem_write  out  1  controller write, one-cycle pulse.
- mem_refresh  out  1  controller refresh, one-cycle pulse.
- mem_addr  out  22  controller address.
- mem_din  out  8  controller write data.
- mem_dout_a  in  8  controller read data, CPU port.
- mem_dout_b  in  8  controller read data, PPU port.
- mem_busy  in  1  controller busy (high during init and during operations).
- refresh_owed  out  3  pending refresh count.
- fail  out  1  sticky: refresh overflow or busy timeout.

Behaviour:
- Reset values: all outputs 0, state IDLE, refresh counter 0, cpu_skip 0, refresh_owed 0.
  - Reset asserted mid-operation aborts immediately; no ack is issued for the aborted access.
- Refresh timer: counts 0..REFRESH_INTERVAL-1, then wraps.
  - On the wrap cycle, refresh_owed increments, saturating at 7.
  - An increment attempted at 7 sets fail.
  - Tick and refresh grant in the same cycle leave refresh_owed unchanged.
  - The timer runs during controller initialisation.
- States: IDLE -> CMD -> WAIT_HI -> WAIT_LO -> DONE -> IDLE.
- IDLE: arbitrates only when mem_busy==0. Priority order:
  1. refresh if refresh_owed >= REFRESH_URGENT;
  2. CPU if cpu_req and cpu_skip == CPU_MAX_SKIP;
  3. PPU if ppu_req;
  4. CPU if cpu_req;
  5. refresh if refresh_owed > 0.
- On a grant:
  - Register mem_addr and mem_din (cpu_din) plus the command bit; the command is visible for exactly the CMD cycle.
  - Refresh grant decrements refresh_owed.
  - PPU grant with cpu_req high increments cpu_skip, saturating at CPU_MAX_SKIP.
  - CPU grant clears cpu_skip.
  - Go to CMD.
- CMD: the mem_* command pulse is high for this cycle only; go to WAIT_HI.
- WAIT_HI: wait for mem_busy==1, then go to WAIT_LO.
  - After BUSY_TIMEOUT cycles without busy: set fail and go to DONE (ack issued, data = 0x00).
- WAIT_LO: when mem_busy==0, capture mem_dout_a into cpu_dout (CPU read) or mem_dout_b into ppu_dout (PPU read); go to DONE.
  - CPU write: cpu_dout is unchanged.
- DONE: the granted client's ack is high for exactly one cycle, with data stable; refresh produces no ack.
  - Requester must drop req on the next edge.
  - DONE→IDLE guarantees the acked request is not re-granted.
- At most one mem_* command bit is high in any cycle.
- At most one access is outstanding; a new grant never occurs while mem_busy==1.
- Minimum access period is 1 + 1 + controller busy length + 1 + 1 cycles.

Test Plan:
- Hold mem_busy=1 for 50 cycles after reset with cpu_req=1 -> no mem_* pulse until mem_busy falls; then mem_read_a pulses exactly once.
- CPU read at 0x380010; model returns 0x5A after 4-cycle busy -> cpu_ack one cycle with cpu_dout=0x5A; mem_addr=0x380010 during CMD.
- cpu_req and ppu_req both held continuously -> grant order PPU, PPU, CPU, PPU, PPU, CPU (CPU_MAX_SKIP=2).
- Block arbitration (mem_busy=1) for 5*REFRESH_INTERVAL with cpu_req=1, then release -> refresh_owed reaches 5; mem_refresh issued before any CPU grant until refresh_owed=3, then CPU is served.
- Hold mem_busy high for 8*REFRESH_INTERVAL -> refresh_owed saturates at 7, fail=1 and stays 1.
- Controller model never raises mem_busy after a CPU write -> after 8 WAIT_HI cycles fail=1 and cpu_ack pulses.
- Assert reset during WAIT_LO -> all outputs 0 immediately, no ack; after release, a CPU write of 0xA5 to 0x3C0000 completes normally.
